fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and load-use hazard controller for the pipelined core, replacing the fixed two-operand combinational forwarding logic. It keeps its own shadow pipeline of destination tags (EX, MEM, WB slots), so the datapath only presents the decode-stage instruction. It issues registered per-operand bypass selects that are valid while the consumer is in EX, and it raises a decode stall on load-use hazards. It supports N read ports, a configurable register file size, an optional hardwired zero register, and an optional write-first register file.

---
 rtl/fwd_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: shadows the EX/MEM/WB destination
// tags, registers per-operand bypass selects for EX, and stalls decode on load-use.
module fwd_hazard_ctrl #(
  parameter int NUM_REGS       = 16,
  parameter int NUM_SRC        = 2,
  parameter bit ZERO_REG_HW    = 1'b1,
  parameter bit RF_WRITE_FIRST = 1'b1,
  parameter int CNT_W          = 16,
  localparam int RW            = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic                  id_we,
  input  logic [RW-1:0]         id_rd,
  input  logic                  id_is_load,
  input  logic [NUM_SRC-1:0]    id_src_used,
  input  logic [NUM_SRC*RW-1:0] id_src_reg,
  input  logic                  hold,
  input  logic                  flush_id,
  output logic                  stall_id,
  output logic [2*NUM_SRC-1:0]  fwd_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  // Destination tag of an in-flight instruction. The load flag is only
  // consulted in EX, so it lives beside the EX slot instead of in every slot.
  typedef struct packed {
    logic          valid;
    logic          we;
    logic [RW-1:0] rd;
  } slot_t;

  localparam logic [1:0] SEL_RF   = 2'b00;
  localparam logic [1:0] SEL_EXM  = 2'b01;
  localparam logic [1:0] SEL_MWB  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

  slot_t              r_ex;
  slot_t              r_mem;
  slot_t              r_wb;
  logic               r_ex_load;
  logic [2*NUM_SRC-1:0] r_fwd_sel;
  logic [CNT_W-1:0]   r_stall_cnt;

  logic [NUM_SRC-1:0]   w_load_use;
  logic [2*NUM_SRC-1:0] w_sel;
  logic                 w_bubble;

  function automatic logic slot_match(input slot_t s, input logic [RW-1:0] r);
    return s.valid && s.we && (s.rd == r) && !(ZERO_REG_HW && (r == '0));
  endfunction

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [RW-1:0] w_reg;
    logic          w_hit_ex;
    logic          w_hit_mem;
    logic          w_hit_wb;

    assign w_reg     = id_src_reg[i*RW +: RW];
    assign w_hit_ex  = slot_match(r_ex, w_reg);
    assign w_hit_mem = slot_match(r_mem, w_reg);
    assign w_hit_wb  = slot_match(r_wb, w_reg);

    assign w_load_use[i] = id_src_used[i] && w_hit_ex && r_ex_load;

    // Youngest producer wins; a write-first RF already returns the WB value.
    always_comb begin
      w_sel[2*i +: 2] = SEL_RF;
      if (id_src_used[i]) begin
        if (w_hit_ex)
          w_sel[2*i +: 2] = SEL_EXM;
        else if (w_hit_mem)
          w_sel[2*i +: 2] = SEL_MWB;
        else if (w_hit_wb)
          w_sel[2*i +: 2] = RF_WRITE_FIRST ? SEL_RF : SEL_HOLD;
      end
    end
  end

  // Decode handshake: the ID instruction advances into EX on a clock edge where
  // id_valid=1, stall_id=0, flush_id=0 and hold=0; every other edge either
  // freezes the pipeline (hold) or inserts a bubble into EX.
  assign stall_id = id_valid && !flush_id && (|w_load_use);
  assign w_bubble = stall_id || flush_id || !id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_ex_load   <= 1'b0;
      r_fwd_sel   <= '0;
      r_stall_cnt <= '0;
    end else if (!hold) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (w_bubble) begin
        r_ex      <= '0;
        r_ex_load <= 1'b0;
        r_fwd_sel <= '0;
      end else begin
        r_ex      <= '{valid: 1'b1, we: id_we, rd: id_rd};
        r_ex_load <= id_is_load;
        r_fwd_sel <= w_sel;
      end
      if (stall_id && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign fwd_sel   = r_fwd_sel;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: one default instance and one with
// RF_WRITE_FIRST=0, ZERO_REG_HW=0, CNT_W=2, both driven by the same stimulus.
module tb_fwd_hazard_ctrl;

  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic          id_we;
  logic [RW-1:0] id_rd;
  logic          id_is_load;
  logic [1:0]    id_src_used;
  logic [2*RW-1:0] id_src_reg;
  logic          hold;
  logic          flush_id;

  logic          stall0, stall1;
  logic [3:0]    fwd0, fwd1;
  logic [15:0]   cnt0;
  logic [1:0]    cnt1;

  int checks = 0;
  int errors = 0;

  // clock / reset
  always #5 clk = ~clk;

  fwd_hazard_ctrl dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_we(id_we), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_src_used(id_src_used), .id_src_reg(id_src_reg),
    .hold(hold), .flush_id(flush_id),
    .stall_id(stall0), .fwd_sel(fwd0), .stall_cnt(cnt0)
  );

  fwd_hazard_ctrl #(
    .ZERO_REG_HW(1'b0), .RF_WRITE_FIRST(1'b0), .CNT_W(2)
  ) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_we(id_we), .id_rd(id_rd),
    .id_is_load(id_is_load), .id_src_used(id_src_used), .id_src_reg(id_src_reg),
    .hold(hold), .flush_id(flush_id),
    .stall_id(stall1), .fwd_sel(fwd1), .stall_cnt(cnt1)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [RW-1:0] rd,
                       input logic ld, input logic [1:0] used,
                       input logic [RW-1:0] s0, input logic [RW-1:0] s1);
    id_valid    = v;
    id_we       = we;
    id_rd       = rd;
    id_is_load  = ld;
    id_src_used = used;
    id_src_reg  = {s1, s0};
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 4'd0, 1'b0, 2'b00, 4'd0, 4'd0);
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; hold = 1'b0; flush_id = 1'b0;
    idle();
    step(); step();
    rst = 1'b0;
    chk("reset_stall0", {31'd0, stall0}, 32'd0);
    chk("reset_fwd0", {28'd0, fwd0}, 32'd0);
    chk("reset_cnt0", {16'd0, cnt0}, 32'd0);
    chk("reset_cnt1", {30'd0, cnt1}, 32'd0);

    // ALU -> ALU: ADD r1 then SUB r6 reading r1 on src0
    drive(1, 1, 4'd1, 0, 2'b00, 4'd0, 4'd0);
    step();
    drive(1, 1, 4'd6, 0, 2'b01, 4'd1, 4'd0);
    chk("alu_nostall", {31'd0, stall0}, 32'd0);
    step();
    chk("alu_fwd0", {28'd0, fwd0}, 32'h1);
    chk("alu_fwd1", {28'd0, fwd1}, 32'h1);

    // Load-use: LDR r3, then ADD r7 reading r3 on src1
    drive(1, 1, 4'd3, 1, 2'b00, 4'd0, 4'd0);
    step();
    chk("ldr_fwd_unused", {28'd0, fwd0}, 32'h0);
    drive(1, 1, 4'd7, 0, 2'b10, 4'd0, 4'd3);
    chk("lu_stall0", {31'd0, stall0}, 32'd1);
    chk("lu_stall1", {31'd0, stall1}, 32'd1);
    step();
    chk("lu_cnt0", {16'd0, cnt0}, 32'd1);
    chk("lu_bubble_fwd", {28'd0, fwd0}, 32'h0);
    chk("lu_release", {31'd0, stall0}, 32'd0);
    step();
    chk("lu_fwd0", {28'd0, fwd0}, 32'h8);
    chk("lu_cnt0_after", {16'd0, cnt0}, 32'd1);

    // Distance 3: producer r5, two independents, consumer of r5
    drive(1, 1, 4'd5, 0, 2'b00, 4'd0, 4'd0); step();
    drive(1, 1, 4'd8, 0, 2'b00, 4'd0, 4'd0); step();
    drive(1, 1, 4'd9, 0, 2'b00, 4'd0, 4'd0); step();
    drive(1, 1, 4'd10, 0, 2'b01, 4'd5, 4'd0);
    chk("d3_nostall", {31'd0, stall0}, 32'd0);
    step();
    chk("d3_fwd_wfirst", {28'd0, fwd0}, 32'h0);
    chk("d3_fwd_hold", {28'd0, fwd1}, 32'h3);

    // Priority: ADD r2, MOV r2, consumer of r2 on both operands
    drive(1, 1, 4'd2, 0, 2'b00, 4'd0, 4'd0); step();
    drive(1, 1, 4'd2, 0, 2'b00, 4'd0, 4'd0); step();
    drive(1, 1, 4'd11, 0, 2'b11, 4'd2, 4'd2);
    step();
    chk("prio_fwd0", {28'd0, fwd0}, 32'h5);
    chk("prio_fwd1", {28'd0, fwd1}, 32'h5);

    // Zero register: writer of r0 then consumer of r0
    drive(1, 1, 4'd0, 0, 2'b00, 4'd0, 4'd0); step();
    drive(1, 1, 4'd12, 0, 2'b01, 4'd0, 4'd0);
    chk("r0_nostall", {31'd0, stall0}, 32'd0);
    step();
    chk("r0_fwd_hw", {28'd0, fwd0}, 32'h0);
    chk("r0_fwd_nohw", {28'd0, fwd1}, 32'h1);

    // Hold during load-use: LDR r4 (reads r12 via EX bypass), consumer of r4
    drive(1, 1, 4'd4, 1, 2'b10, 4'd0, 4'd12); step();
    chk("hold_pre_fwd", {28'd0, fwd0}, 32'h4);
    drive(1, 1, 4'd13, 0, 2'b01, 4'd4, 4'd0);
    chk("hold_stall", {31'd0, stall0}, 32'd1);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_fwd", {28'd0, fwd0}, 32'h4);
      chk("hold_cnt", {16'd0, cnt0}, 32'd1);
    end
    hold = 1'b0;
    #1;
    chk("hold_slots_kept", {31'd0, stall0}, 32'd1);
    flush_id = 1'b1;
    #1;
    chk("flush_stall", {31'd0, stall0}, 32'd0);
    step();
    flush_id = 1'b0;
    chk("flush_cnt", {16'd0, cnt0}, 32'd1);
    chk("flush_fwd", {28'd0, fwd0}, 32'h0);

    // Reset mid-stream: LDR r14 (reads r4 from MEM), consumer of r14 in ID
    drive(1, 1, 4'd14, 1, 2'b10, 4'd0, 4'd4); step();
    chk("rst_pre_fwd", {28'd0, fwd0}, 32'h8);
    drive(1, 1, 4'd15, 0, 2'b01, 4'd14, 4'd0);
    chk("rst_pre_stall", {31'd0, stall0}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_stall", {31'd0, stall0}, 32'd0);
    chk("rst_fwd", {28'd0, fwd0}, 32'h0);
    chk("rst_cnt0", {16'd0, cnt0}, 32'd0);
    chk("rst_cnt1", {30'd0, cnt1}, 32'd0);

    // Repeated load-use: CNT_W=2 instance saturates at 3
    for (int n = 1; n <= 4; n++) begin
      drive(1, 1, 4'd3, 1, 2'b00, 4'd0, 4'd0); step();
      drive(1, 1, 4'd5, 0, 2'b01, 4'd3, 4'd0);
      chk("sat_stall", {31'd0, stall1}, 32'd1);
      step();
      step();
      chk("sat_cnt0", {16'd0, cnt0}, n);
      chk("sat_cnt1", {30'd0, cnt1}, (n > 3) ? 32'd3 : n);
    end

    idle();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
